serial_adder: RTL and testbench
===============================

SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 Parameter: WIDTH, default 8, operand/result width in bits (legal range 1..32).
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  asynchronous, active-high reset; one clock, no other clock or reset inputs.
REQ-004 Port: start  input  1  request to add a and b; sampled on rising clk.
REQ-005 Port: a  input  WIDTH  operand A, captured only on an accepted start.
REQ-006 Port: b  input  WIDTH  operand B, captured only on an accepted start.
REQ-007 Port: busy  output  1  high while an addition is in progress.
REQ-008 Port: done  output  1  one-cycle pulse marking new sum/cout.
REQ-009 Port: sum  output  WIDTH  registered result, (a+b) mod 2^WIDTH.
REQ-010 Port: cout  output  1  registered carry out of bit WIDTH-1.

Function
REQ-011 The block SHALL add bit-serially, LSB first, one bit per clock, using one half-adder-pair (full-adder) cell and a 1-bit carry flip-flop.
REQ-012 The FSM SHALL have states IDLE, RUN and FIN, encoded as registered state, with no other reachable states.
REQ-013 IDLE: start=1 at an edge SHALL load a and b into shift registers, clear the carry flop, clear the bit counter, and go to RUN.
REQ-014 RUN: each edge SHALL compute s=a0^b0^c and c'=(a0&b0)|(c&(a0^b0)), shift s into the MSB of the internal result register, shift both operand registers right by one, and increment the counter.
REQ-015 RUN SHALL last exactly WIDTH edges; on the WIDTH-th RUN edge the final bit and carry SHALL be written to sum and cout, and the state SHALL go to FIN.
REQ-016 FIN SHALL last one cycle with done=1; the next edge SHALL return to IDLE, or, if start=1 at that edge, behave as REQ-013 (back-to-back accept).
REQ-017 busy SHALL be 1 exactly in RUN; done SHALL be 1 exactly in FIN; both Moore outputs.
REQ-018 Latency: start accepted at edge k -> done high during the cycle after edge k+WIDTH; sum/cout valid from that same edge.
REQ-019 start while in RUN SHALL be ignored; operands captured earlier SHALL not change.
REQ-020 a and b SHALL be ignored except at an accepted start edge.
REQ-021 sum and cout SHALL hold their last result until the next completion edge; they SHALL NOT toggle during RUN.
REQ-022 Overflow SHALL wrap: sum=(a+b) mod 2^WIDTH, cout=1 iff a+b >= 2^WIDTH.
REQ-023 WIDTH=1 SHALL work: RUN lasts one edge; result equals a half-adder (sum=a^b, cout=a&b).

Reset
REQ-024 rst=1 SHALL, asynchronously and without a clock edge, force state=IDLE, busy=0, done=0, sum=0, cout=0, carry flop=0, counter=0, operand registers=0.
REQ-025 rst asserted mid-RUN SHALL abort the operation; no done pulse SHALL follow it, and sum/cout SHALL read 0.
REQ-026 After rst deasserts, the first rising edge with start=1 SHALL be accepted normally.

Verification
REQ-027 WIDTH=8, a=3, b=5, start for one cycle -> busy for 8 cycles, done one cycle later, sum=8, cout=0.
REQ-028 WIDTH=8, a=255, b=1 -> sum=0, cout=1; then a=255, b=255 -> sum=254, cout=1.
REQ-029 WIDTH=8, start held high for 20 cycles with a/b changing every cycle -> first captured pair is added, completes at edge k+8; the FIN-cycle start is accepted back-to-back; no mid-RUN recapture.
REQ-030 WIDTH=8, start a=170, b=85, rst pulsed (not on an edge) after 4 RUN cycles -> busy=0, done=0, sum=0, cout=0 immediately; no later done.
REQ-031 WIDTH=1, all four (a,b) pairs 00,01,10,11 -> (sum,cout) = (0,0),(1,0),(1,0),(0,1), each with done two edges after start.
REQ-032 Random self-check: 1000 random WIDTH=8 pairs, compare {cout,sum} with a+b at each done; zero mismatches.

Source files
------------

// File: rtl/serial_adder.sv
// serial_adder: bit-serial adder, LSB first, one bit per clock.
// A single full-adder cell and a 1-bit carry flop walk through the operands;
// the partial sum is collected in an internal shift register and copied to
// the sum/cout outputs only on the final RUN edge, so the outputs hold the
// previous result for the whole operation.
//
// Ports:
//   clk   - clock, all state updates on rising edge
//   rst   - asynchronous active-high reset
//   start - request; accepted in IDLE or FIN (back-to-back)
//   a, b  - operands, captured only on an accepted start
//   busy  - high exactly while in RUN
//   done  - one-cycle pulse (FIN) marking a new sum/cout
//   sum   - registered (a+b) mod 2^WIDTH
//   cout  - registered carry out of bit WIDTH-1
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    // Internal result register only needs the WIDTH-1 bits gathered before
    // the final edge; the last bit goes straight to sum.
    localparam int RW = (WIDTH > 1) ? WIDTH - 1 : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [WIDTH-1:0] a_sh, b_sh;
    logic [RW-1:0]    res, res_nxt;
    logic [WIDTH-1:0] full_nxt;
    logic [CW-1:0]    cnt;
    logic             carry;
    logic             s, c_nxt;
    logic             last;
    logic             load;

    // full-adder cell
    assign s     = a_sh[0] ^ b_sh[0] ^ carry;
    assign c_nxt = (a_sh[0] & b_sh[0]) | (carry & (a_sh[0] ^ b_sh[0]));

    assign last = (cnt == CW'(WIDTH - 1));
    assign load = start && (state == IDLE || state == FIN);

    // Result vector as it will look after this edge's bit is shifted in.
    generate
        if (WIDTH > 1) begin : g_wide
            assign full_nxt = {s, res};
            assign res_nxt  = full_nxt[WIDTH-1:1];
        end else begin : g_one
            assign full_nxt = s;
            assign res_nxt  = 1'b0;
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: if (start) state_nxt = RUN;
            RUN: begin
                busy = 1'b1;
                if (last) state_nxt = FIN;
            end
            FIN: begin
                done      = 1'b1;
                state_nxt = start ? RUN : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sh  <= '0;
            b_sh  <= '0;
            res   <= '0;
            cnt   <= '0;
            carry <= 1'b0;
            sum   <= '0;
            cout  <= 1'b0;
        end else if (load) begin
            a_sh  <= a;
            b_sh  <= b;
            cnt   <= '0;
            carry <= 1'b0;
        end else if (state == RUN) begin
            a_sh  <= a_sh >> 1;
            b_sh  <= b_sh >> 1;
            res   <= res_nxt;
            carry <= c_nxt;
            cnt   <= cnt + CW'(1);
            if (last) begin
                sum  <= full_nxt;
                cout <= c_nxt;
            end
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
module tb_serial_adder;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [8:0] val;
        int         at;
    } exp_t;

    exp_t q8[$];
    exp_t q1[$];

    // WIDTH=8 instance
    logic       start8, busy8, done8, cout8;
    logic [7:0] a8, b8, sum8;
    serial_adder #(.WIDTH(8)) u8 (
        .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
    );

    // WIDTH=1 instance
    logic start1, busy1, done1, cout1;
    logic [0:0] a1, b1, sum1;
    serial_adder #(.WIDTH(1)) u1 (
        .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1),
        .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // monitors: pop the scoreboard whenever a done pulse is seen
    always @(negedge clk) begin
        if (rst === 1'b0 && done8 === 1'b1) begin
            if (q8.size() == 0) begin
                tests++; fails++;
                $display("FAIL done8_unexpected: got done at cycle %0d, expected none", cyc);
            end else begin
                exp_t e;
                e = q8.pop_front();
                check("sum8", {55'd0, cout8, sum8}, {55'd0, e.val});
                check("lat8", cyc, e.at);
            end
        end
    end

    always @(negedge clk) begin
        if (rst === 1'b0 && done1 === 1'b1) begin
            if (q1.size() == 0) begin
                tests++; fails++;
                $display("FAIL done1_unexpected: got done at cycle %0d, expected none", cyc);
            end else begin
                exp_t e;
                e = q1.pop_front();
                check("sum1", {62'd0, cout1, sum1}, {55'd0, e.val});
                check("lat1", cyc, e.at);
            end
        end
    end

    // issue one request; caller is at a negedge
    task automatic issue8(input logic [7:0] x, input logic [7:0] y, input logic [8:0] v);
        start8 = 1'b1; a8 = x; b8 = y;
        q8.push_back('{v, cyc + 9});
        @(negedge clk);
        start8 = 1'b0; a8 = ~x; b8 = ~y;
    endtask

    task automatic wait8();
        int t = 0;
        while ((q8.size() != 0 || busy8 || done8) && t < 40) begin
            @(negedge clk); t++;
        end
        if (q8.size() != 0 || busy8) begin
            tests++; fails++;
            $display("FAIL wait8_timeout: got %0d pending, expected 0", q8.size());
        end
    endtask

    task automatic wait1();
        int t = 0;
        while ((q1.size() != 0 || busy1 || done1) && t < 10) begin
            @(negedge clk); t++;
        end
        if (q1.size() != 0 || busy1) begin
            tests++; fails++;
            $display("FAIL wait1_timeout: got %0d pending, expected 0", q1.size());
        end
    endtask

    initial begin
        int bc;
        logic [1:0] p;
        logic [8:0] held_exp[3];
        logic [1:0] w1_exp[4];
        held_exp = '{9'd110, 9'd137, 9'd164};
        w1_exp   = '{2'd0, 2'd1, 2'd1, 2'd2};

        start8 = 0; a8 = 0; b8 = 0;
        start1 = 0; a1 = 0; b1 = 0;

        // reset state
        repeat (2) @(negedge clk);
        check("rst_busy8", busy8, 0);
        check("rst_done8", done8, 0);
        check("rst_sum8",  {cout8, sum8}, 0);
        check("rst_sum1",  {busy1, done1, cout1, sum1}, 0);
        rst = 1'b0;
        @(negedge clk);

        // 3 + 5: busy for 8 cycles, sum held during RUN
        issue8(8'd3, 8'd5, 9'd8);
        bc = 0;
        for (int i = 0; i < 8; i++) begin
            if (busy8) bc++;
            if (i == 4) check("sum_hold", {cout8, sum8}, 0);
            @(negedge clk);
        end
        check("busy_len", bc, 8);
        check("fin_busy", busy8, 0);
        check("fin_done", done8, 1);
        wait8();

        // overflow wrap
        issue8(8'd255, 8'd1, 9'h100);   wait8();
        issue8(8'd255, 8'd255, 9'h1FE); wait8();

        // start held 20 cycles; accepts at 0, 9 (FIN back-to-back), 18
        for (int i = 0; i < 20; i++) begin
            start8 = 1'b1;
            a8 = 8'(10 + i);
            b8 = 8'(100 + 2 * i);
            if (i == 0)  q8.push_back('{held_exp[0], cyc + 9});
            if (i == 9)  q8.push_back('{held_exp[1], cyc + 9});
            if (i == 18) q8.push_back('{held_exp[2], cyc + 9});
            @(negedge clk);
        end
        start8 = 1'b0;
        wait8();

        // reset mid-RUN: outputs clear immediately, no later done
        start8 = 1'b1; a8 = 8'd170; b8 = 8'd85;
        @(negedge clk);
        start8 = 1'b0;
        repeat (4) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("abort_busy", busy8, 0);
        check("abort_done", done8, 0);
        check("abort_sum",  {cout8, sum8}, 0);
        #1 rst = 1'b0;
        repeat (15) @(negedge clk);
        check("abort_idle", {busy8, done8, cout8, sum8}, 0);

        // first start after reset accepted normally
        issue8(8'd1, 8'd2, 9'd3); wait8();

        // WIDTH=1: half adder, done two edges after start
        for (int i = 0; i < 4; i++) begin
            p = 2'(i);
            start1 = 1'b1; a1 = p[1]; b1 = p[0];
            q1.push_back('{{7'd0, w1_exp[i]}, cyc + 2});
            @(negedge clk);
            start1 = 1'b0;
            wait1();
        end

        // random pairs
        for (int i = 0; i < 1000; i++) begin
            logic [7:0] x, y;
            x = 8'($urandom_range(0, 255));
            y = 8'($urandom_range(0, 255));
            issue8(x, y, {1'b0, x} + {1'b0, y});
            wait8();
        end

        check("q8_empty", q8.size(), 0);
        check("q1_empty", q1.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
